// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multi-cycle multiply/divide unit: decodes mult/div in DX,
// pulses the MDU start, tracks the operation with a watchdog and holds the result
// until writeback accepts it.
module multdiv_ctrl #(
    parameter int unsigned MAX_CYCLES    = 40,
    parameter int unsigned CNT_W         = 6,
    parameter int unsigned MULT_EXC_CODE = 4,
    parameter int unsigned DIV_EXC_CODE  = 5,
    parameter int unsigned TIMEOUT_CODE  = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dx_ir_in,
    input  logic        dx_valid,
    input  logic        dx_flush,
    output logic        mdu_ctrl_mult,
    output logic        mdu_ctrl_div,
    input  logic [31:0] mdu_result,
    input  logic        mdu_exception,
    input  logic        mdu_result_rdy,
    input  logic        wb_ack,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        multdiv_is_running,
    output logic        multdiv_result_ready,
    output logic        timeout_err
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned OPC_W  = 5;

    localparam logic [REG_W-1:0] EXC_RD   = REG_W'(30);
    localparam logic [OPC_W-1:0] OPC_ALU  = OPC_W'(0);
    localparam logic [OPC_W-1:0] ALU_MULT = OPC_W'(6);
    localparam logic [OPC_W-1:0] ALU_DIV  = OPC_W'(7);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [REG_W-1:0]   rd_q, rd_d;
    logic               op_div_q, op_div_d;
    logic [REG_W-1:0]   wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;
    logic               mult_q, mult_d;
    logic               div_q, div_d;
    logic               running_q, running_d;
    logic               ready_q, ready_d;
    logic               timeout_q, timeout_d;

    logic [OPC_W-1:0]   opcode_c;
    logic [OPC_W-1:0]   alu_op_c;
    logic [REG_W-1:0]   dx_rd_c;
    logic               is_mult_c;
    logic               is_div_c;
    logic               launch_c;
    logic               unused_ir_bits_c;

    // Instruction field decode and launch qualification
    always_comb begin
        opcode_c         = dx_ir_in[31:27];
        alu_op_c         = dx_ir_in[6:2];
        dx_rd_c          = dx_ir_in[26:22];
        is_mult_c        = (opcode_c == OPC_ALU) && (alu_op_c == ALU_MULT);
        is_div_c         = (opcode_c == OPC_ALU) && (alu_op_c == ALU_DIV);
        launch_c         = dx_valid && !dx_flush && (is_mult_c || is_div_c);
        unused_ir_bits_c = ^{dx_ir_in[21:7], dx_ir_in[1:0]};
    end

    // Next-state and next-output logic; everything holds unless a transition updates it
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_d      = rd_q;
        op_div_d  = op_div_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        timeout_d = timeout_q;
        mult_d    = 1'b0;
        div_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (launch_c) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    rd_d     = dx_rd_c;
                    op_div_d = is_div_c;
                    mult_d   = !is_div_c;
                    div_d    = is_div_c;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mdu_result_rdy) begin
                    state_d = S_DONE;
                    if (mdu_exception) begin
                        wb_rd_d   = EXC_RD;
                        wb_data_d = op_div_q ? DATA_W'(DIV_EXC_CODE) : DATA_W'(MULT_EXC_CODE);
                    end else begin
                        wb_rd_d   = rd_q;
                        wb_data_d = mdu_result;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    wb_rd_d   = EXC_RD;
                    wb_data_d = DATA_W'(TIMEOUT_CODE);
                    timeout_d = 1'b1;
                end
            end
            S_DONE: begin
                if (wb_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        running_d = (state_d != S_IDLE);
        ready_d   = (state_d == S_DONE);
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rd_q      <= '0;
            op_div_q  <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            mult_q    <= 1'b0;
            div_q     <= 1'b0;
            running_q <= 1'b0;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_q      <= rd_d;
            op_div_q  <= op_div_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            mult_q    <= mult_d;
            div_q     <= div_d;
            running_q <= running_d;
            ready_q   <= ready_d;
            timeout_q <= timeout_d;
        end
    end

    assign mdu_ctrl_mult        = mult_q;
    assign mdu_ctrl_div         = div_q;
    assign wb_rd                = wb_rd_q;
    assign wb_data              = wb_data_q;
    assign multdiv_is_running   = running_q;
    assign multdiv_result_ready = ready_q;
    assign timeout_err          = timeout_q;

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequences the shared multi-cycle multiply/divide unit (MDU) for the 5-stage pipeline.
- Decodes mult/div in DX, issues a one-cycle start pulse to the MDU, and tracks the operation to completion.
- Holds the result until the writeback port accepts it.
- Drives multdiv_is_running and multdiv_result_ready, which the hazard/stall logic consumes.

Parameters:
- MAX_CYCLES, 40: watchdog limit on RUN cycles before the operation is forced to complete as a timeout.
- CNT_W, 6: width of the cycle counter; must satisfy 2^CNT_W > MAX_CYCLES.
- MULT_EXC_CODE, 4: value written to $r30 on a multiply exception.
- DIV_EXC_CODE, 5: value written to $r30 on a divide exception.
- TIMEOUT_CODE, 6: value written to $r30 on a watchdog timeout.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- dx_ir_in  input  32  instruction in the DX stage.
- dx_valid  input  1  DX holds a real (non-bubble) instruction.
- dx_flush  input  1  DX is being squashed this cycle (taken branch/jump).
- mdu_ctrl_mult  output  1  one-cycle MDU multiply start.
- mdu_ctrl_div  output  1  one-cycle MDU divide start.
- mdu_result  input  32  MDU result.
- mdu_exception  input  1  MDU overflow or divide-by-zero; valid with mdu_result_rdy.
- mdu_result_rdy  input  1  MDU result valid this cycle.
- wb_ack  input  1  writeback port accepted the held result this cycle.
- wb_rd  output  5  destination register of the held result.
- wb_data  output  32  value to write.
- multdiv_is_running  output  1  an operation is in flight or awaiting writeback.
- multdiv_result_ready  output  1  wb_rd/wb_data are valid.
- timeout_err  output  1  sticky flag; set when a watchdog timeout occurs, cleared only by reset.

Behaviour:
- Decode:
  - opcode = dx_ir_in[31:27]; ALU op = dx_ir_in[6:2]; rd = dx_ir_in[26:22].
  - is_mult = (opcode == 00000) & (ALU op == 00110).
  - is_div = (opcode == 00000) & (ALU op == 00111).
  - launch = dx_valid & ~dx_flush & (is_mult | is_div).
- Reset (reset == 0, asynchronous): state = IDLE, counter = 0, and every output is 0 (wb_rd, wb_data, both ctrl pulses, multdiv_is_running, multdiv_result_ready, timeout_err). Reset during RUN or DONE abandons the operation; late MDU responses are then ignored.
- IDLE:
  - On launch at edge k: latch rd and op type, clear counter, move to RUN.
  - Exactly one of mdu_ctrl_mult / mdu_ctrl_div is high for the single cycle after edge k (registered).
  - Without launch: stay in IDLE. mdu_result_rdy is ignored in IDLE.
- RUN:
  - multdiv_is_running = 1; the counter increments every cycle.
  - On mdu_result_rdy:
    - No exception: capture wb_data = mdu_result, wb_rd = latched rd.
    - mdu_exception = 1: wb_rd = 30, wb_data = MULT_EXC_CODE or DIV_EXC_CODE according to op type.
    - Then move to DONE.
  - Watchdog: if the counter reaches MAX_CYCLES with no rdy, wb_rd = 30, wb_data = TIMEOUT_CODE, timeout_err set, move to DONE.
  - rdy arriving on the same edge as the watchdog expiry wins; no timeout is recorded.
  - dx_flush and launch are ignored in RUN; the operation is already committed.
- DONE:
  - multdiv_is_running = 1, multdiv_result_ready = 1; wb_rd and wb_data are held stable.
  - On wb_ack: move to IDLE; both flags drop the next cycle.
  - A launch present in the same cycle as wb_ack is not accepted. DX is stalled, so it is re-presented and accepted from IDLE on the following cycle.
  - Extra mdu_result_rdy pulses in DONE are ignored.
- Latency: a launch at edge k with MDU rdy sampled at edge k+n gives multdiv_result_ready = 1 from cycle k+n+1.
- Start pulses: never more than one cycle wide; never issued outside the IDLE→RUN transition.

Test Plan:
- Reset mid-RUN: assert reset low asynchronously → all outputs 0 immediately, state IDLE; a later rdy pulse produces no result_ready.
- mult $r5: launch with dx_ir_in = 0x01400018 (rd=5, ALU op 00110) → mdu_ctrl_mult high exactly one cycle; rdy after 17 cycles with result 0x0000002A → wb_rd = 5, wb_data = 0x2A; hold 3 cycles with wb_ack = 0 → values stable; wb_ack = 1 → IDLE next cycle.
- div with exception: rd = 7, rdy together with mdu_exception = 1 → wb_rd = 30, wb_data = 5.
- Watchdog: no rdy for MAX_CYCLES = 40 → wb_rd = 30, wb_data = 6, timeout_err = 1 and stays set after wb_ack.
- Flush on launch: dx_flush = 1 with a mult in DX → no ctrl pulse, multdiv_is_running stays 0. Also: rdy on the same edge as watchdog expiry → normal result, timeout_err = 0.
- Back-to-back: a second mult held in DX while DONE, with wb_ack → the second launch is accepted the cycle after IDLE is re-entered, producing exactly one new ctrl pulse.
